// File: rtl/mips_issue_ctrl.sv
// mips_issue_ctrl: DEPTH-entry instruction queue that feeds a MIPS datapath one R-type word per cycle.
// Define MIPS_ISSUE_RETIRE_CNT_EN to build the 16-bit retired-instruction counter and its port.
module mips_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic [31:0] instr_out,
    output logic        issue_valid,
    output logic [1:0]  state
`ifdef MIPS_ISSUE_RETIRE_CNT_EN
    ,
    output logic [15:0] retired
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        HALT  = 2'b11
    } state_t;

    state_t        cur_state;
    state_t        next_state;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [31:0]   head;
    logic          head_is_break;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cur_state <= IDLE;
        else
            cur_state <= next_state;
    end

    // DRAIN falls back to IDLE once this cycle's pop leaves nothing behind.
    always_comb begin
        next_state = cur_state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (cur_state)
                IDLE:  if (start) next_state = RUN;
                RUN: begin
                    if (pop && head_is_break)
                        next_state = HALT;
                    else if (!start)
                        next_state = DRAIN;
                end
                DRAIN: begin
                    if (pop && head_is_break)
                        next_state = HALT;
                    else if (start)
                        next_state = RUN;
                    else if (count == '0 || (pop && count == CW'(1) && !push))
                        next_state = IDLE;
                end
                HALT:    next_state = HALT;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready      = rst_n && (count < FULL_COUNT) && (cur_state != HALT) && !flush;
        push          = in_valid && in_ready;
        pop           = ((cur_state == RUN) || (cur_state == DRAIN)) && (count != '0) && !flush;
        head          = mem[rd_ptr];
        head_is_break = (head[31:26] == 6'd0) && (head[5:0] == 6'h0D);
        state         = cur_state;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_instr;
    end

    // A popped BREAK is consumed but never reaches the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            instr_out   <= 32'h0;
            issue_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            instr_out   <= 32'h0;
            issue_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            instr_out   <= (pop && !head_is_break) ? head : 32'h0;
            issue_valid <= pop && !head_is_break;
        end
    end

`ifdef MIPS_ISSUE_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired <= 16'h0;
        else if (flush)
            retired <= 16'h0;
        else if (issue_valid)
            retired <= retired + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mips_issue_ctrl.sv
// tb_mips_issue_ctrl: directed scenarios plus randomized traffic checked against a queue-based model.
// Build with MIPS_ISSUE_RETIRE_CNT_EN defined to also exercise the retired counter.
module tb_mips_issue_ctrl;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic [31:0] instr_out;
    logic        issue_valid;
    logic [1:0]  state;
`ifdef MIPS_ISSUE_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    int total;
    int bad;

    mips_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .instr_out   (instr_out),
        .issue_valid (issue_valid),
        .state       (state)
`ifdef MIPS_ISSUE_RETIRE_CNT_EN
        ,
        .retired     (retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic s, input logic f, input logic v, input logic [31:0] w);
        @(negedge clk);
        start    = s;
        flush    = f;
        in_valid = v;
        in_instr = w;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_5678);
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
        total++; if (state !== 2'b00) begin bad++; $display("[TB] FAIL reset_state: got %b want 00", state); end
        total++; if (instr_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_instr_out: got %h want 0", instr_out); end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_issue_valid: got %b want 0", issue_valid); end
`ifdef MIPS_ISSUE_RETIRE_CNT_EN
        total++; if (retired !== 16'h0) begin bad++; $display("[TB] FAIL reset_retired: got %0d want 0", retired); end
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_issue();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h012A_4020);
        advance();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_no_pop: got %b want 0", issue_valid); end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        advance();
        total++; if (state !== 2'b01) begin bad++; $display("[TB] FAIL single_run_state: got %b want 01", state); end
        advance();
        total++; if (instr_out !== 32'h012A_4020) begin bad++; $display("[TB] FAIL single_instr: got %h want 012a4020", instr_out); end
        total++; if (issue_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid: got %b want 1", issue_valid); end
        advance();
        total++; if (instr_out !== 32'h0 || issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_nop_after: got %h/%b want 0/0", instr_out, issue_valid); end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        advance();
        advance();
        total++; if (state !== 2'b00) begin bad++; $display("[TB] FAIL single_back_idle: got %b want 00", state); end
    endtask

    task automatic test_full();
        logic pend;
        logic took;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0101 + 32'(i));
            total++;
            if (in_ready !== (i < 4)) begin bad++; $display("[TB] FAIL full_ready_%0d: got %b want %b", i, in_ready, (i < 4)); end
            if (i < 4) advance();
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0105);
        advance();
        pend = 1'b1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, pend, 32'h0000_0105);
            if (k == 0) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_blocks_on_pop: got %b want 0", in_ready); end
            end
            took = pend && in_ready;
            advance();
            if (took) pend = 1'b0;
            total++;
            if (instr_out !== 32'h0000_0101 + 32'(k) || issue_valid !== 1'b1) begin
                bad++; $display("[TB] FAIL full_issue_%0d: got %h/%b want %h/1", k, instr_out, issue_valid, 32'h0000_0101 + 32'(k));
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        advance();
        advance();
        total++; if (state !== 2'b00) begin bad++; $display("[TB] FAIL full_back_idle: got %b want 00", state); end
    endtask

    task automatic test_break();
        logic [31:0] words [3];
        words[0] = 32'h0000_0020;
        words[1] = 32'h0000_000D;
        words[2] = 32'h0000_0022;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, words[i]);
            advance();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        advance();
        advance();
        total++; if (instr_out !== 32'h20 || issue_valid !== 1'b1) begin bad++; $display("[TB] FAIL break_first: got %h/%b want 20/1", instr_out, issue_valid); end
        advance();
        total++; if (state !== 2'b11) begin bad++; $display("[TB] FAIL break_halt: got %b want 11", state); end
        total++; if (instr_out !== 32'h0 || issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL break_nop: got %h/%b want 0/0", instr_out, issue_valid); end
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0024);
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL halt_in_ready: got %b want 0", in_ready); end
        advance();
        total++; if (state !== 2'b11 || issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_stays: got %b/%b want 11/0", state, issue_valid); end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        advance();
        total++; if (state !== 2'b00) begin bad++; $display("[TB] FAIL flush_state: got %b want 00", state); end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            advance();
            total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_emptied_%0d: got %b/%h want 0", i, issue_valid, instr_out); end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        advance();
        advance();
        total++; if (state !== 2'b00) begin bad++; $display("[TB] FAIL break_back_idle: got %b want 00", state); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0030 + 32'(i));
            advance();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        advance();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            advance();
            total++;
            if (instr_out !== 32'h0000_0030 + 32'(k) || issue_valid !== 1'b1 || state !== ((k == 2) ? 2'b00 : 2'b10)) begin
                bad++; $display("[TB] FAIL drain_issue_%0d: got %h/%b st=%b", k, instr_out, issue_valid, state);
            end
        end
        advance();
        total++; if (issue_valid !== 1'b0 || state !== 2'b00) begin bad++; $display("[TB] FAIL drain_done: got %b st=%b want 0 st=00", issue_valid, state); end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0040 + 32'(i));
            advance();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        advance();
        advance();
        advance();
        total++; if (instr_out !== 32'h41) begin bad++; $display("[TB] FAIL midrun_pre: got %h want 41", instr_out); end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (instr_out !== 32'h0 || state !== 2'b00 || issue_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL midrun_async: got %h st=%b v=%b r=%b", instr_out, state, issue_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            advance();
            total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrun_no_issue_%0d: got %b/%h want 0", i, issue_valid, instr_out); end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        advance();
        advance();
        total++; if (state !== 2'b00) begin bad++; $display("[TB] FAIL midrun_back_idle: got %b want 00", state); end
    endtask

`ifdef MIPS_ISSUE_RETIRE_CNT_EN
    task automatic test_retired();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0050 + 32'(i));
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            advance();
        end
        total++; if (retired !== 16'd6) begin bad++; $display("[TB] FAIL retired_six: got %0d want 6", retired); end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        advance();
        total++; if (retired !== 16'd0) begin bad++; $display("[TB] FAIL retired_flush: got %0d want 0", retired); end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        advance();
    endtask
`endif

    // Reference model: a word queue plus the four operating modes, advanced one clock at a time.
    task automatic test_random();
        logic [31:0] mq [$];
        int          m_state;
        logic [31:0] m_out;
        logic        m_iv;
        logic [15:0] m_ret;
        logic        s, f, v, exp_ready, popped, brk;
        logic [31:0] w, wd;
        int          size_before;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        mq.delete();
        m_state = 0;
        m_out = 32'h0;
        m_iv = 1'b0;
        m_ret = 16'h0;
        for (int n = 0; n < 400; n++) begin
            s = ($urandom_range(0, 9) < 7);
            f = (m_state == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 9) < 6);
            w = ($urandom_range(0, 9) == 0) ? {6'h0, 20'($urandom), 6'h0D} : $urandom;
            applyStimulus(s, f, v, w);
            exp_ready = (mq.size() < DEPTH) && (m_state != 3) && !f;
            total++; if (in_ready !== exp_ready) begin bad++; $display("[TB] FAIL rand_in_ready@%0d: got %b want %b", n, in_ready, exp_ready); end
            if (f) begin
                mq.delete();
                m_state = 0;
                m_out = 32'h0;
                m_iv = 1'b0;
                m_ret = 16'h0;
            end else begin
                m_ret = m_ret + 16'(m_iv);
                size_before = mq.size();
                popped = 1'b0;
                brk = 1'b0;
                wd = 32'h0;
                if ((m_state == 1 || m_state == 2) && size_before > 0) begin
                    wd = mq.pop_front();
                    popped = 1'b1;
                    brk = (wd[31:26] == 6'd0) && (wd[5:0] == 6'h0D);
                end
                if (v && exp_ready) mq.push_back(w);
                m_out = (popped && !brk) ? wd : 32'h0;
                m_iv = popped && !brk;
                case (m_state)
                    0: if (s) m_state = 1;
                    1: if (brk) m_state = 3; else if (!s) m_state = 2;
                    2: if (brk) m_state = 3;
                       else if (s) m_state = 1;
                       else if (size_before == 0 || (popped && mq.size() == 0)) m_state = 0;
                    default: m_state = 3;
                endcase
            end
            advance();
            total++; if (instr_out !== m_out) begin bad++; $display("[TB] FAIL rand_instr@%0d: got %h want %h", n, instr_out, m_out); end
            total++; if (issue_valid !== m_iv) begin bad++; $display("[TB] FAIL rand_valid@%0d: got %b want %b", n, issue_valid, m_iv); end
            total++; if (state !== 2'(m_state)) begin bad++; $display("[TB] FAIL rand_state@%0d: got %b want %0d", n, state, m_state); end
`ifdef MIPS_ISSUE_RETIRE_CNT_EN
            total++; if (retired !== m_ret) begin bad++; $display("[TB] FAIL rand_retired@%0d: got %0d want %0d", n, retired, m_ret); end
`endif
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_instr = 32'h0;
        test_reset();
        test_single_issue();
        test_full();
        test_break();
        test_drain();
        test_reset_mid_run();
`ifdef MIPS_ISSUE_RETIRE_CNT_EN
        test_retired();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
